// File: rtl/ciq_pkg.sv
// ciq_pkg: shared constants and types for the collapsing issue queue (CIQ).
//   CIQ_DEPTH  - number of CIQ entries (power of 2)
//   DECODE_NUM - decode width, i.e. allocation slots per cycle
//   CIQ_AW     - CIQ entry address width
//   ciq_addr_t - one CIQ entry address
package ciq_pkg;

  localparam int CIQ_DEPTH  = 16;
  localparam int DECODE_NUM = 4;
  localparam int CIQ_AW     = $clog2(CIQ_DEPTH);

  typedef logic [CIQ_AW-1:0] ciq_addr_t;

endpackage

// File: rtl/ciq_ffs.sv
// ciq_ffs: combinational find-first-set, scanning from bit 0 upward.
// Ports:
//   vec    (in)  - vector to scan
//   idx    (out) - index of the lowest set bit, 0 when none is set
//   found  (out) - 1 when any bit of vec is set
//   onehot (out) - one-hot of the lowest set bit, all zero when none is set
module ciq_ffs #(
  parameter  int WIDTH = 16,
  localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IW-1:0]    idx,
  output logic             found,
  output logic [WIDTH-1:0] onehot
);

  // Walk from the top down so the last hit written is the lowest set bit.
  always_comb begin
    idx    = '0;
    found  = 1'b0;
    onehot = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx       = IW'(i);
        found     = 1'b1;
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ciq_allocation.sv
// ciq_allocation: picks the first DECODE_NUM free CIQ entries (lowest index
// first) for newly decoded instructions. Results are registered: the free
// vector sampled on edge N is presented after edge N until edge N+1.
// There is no handshake; a fresh result is produced every cycle.
// Ports:
//   clk        (in)  - clock, rising edge
//   rst_n      (in)  - synchronous active-low reset, clears all outputs
//   ciq_free   (in)  - bit i = 1 means CIQ entry i is free
//   free_addr  (out) - [DECODE_NUM-1:0] entry address allocated to slot k
//   free_valid (out) - bit k = 1 means free_addr[k] is a genuinely free entry
//                      (thermometer coded from bit 0; unused slots read 0)
module ciq_allocation #(
  parameter  int DECODE_NUM = ciq_pkg::DECODE_NUM,
  parameter  int CIQ_DEPTH  = ciq_pkg::CIQ_DEPTH,
  localparam int AW         = $clog2(CIQ_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CIQ_DEPTH-1:0]  ciq_free,
  output logic [AW-1:0]         free_addr [DECODE_NUM-1:0],
  output logic [DECODE_NUM-1:0] free_valid
);

  import ciq_pkg::*;

  // stage_vec[k] is the free vector seen by slot k: everything already
  // claimed by slots 0..k-1 has been removed.
  logic [CIQ_DEPTH-1:0] stage_vec [DECODE_NUM:0];
  logic [CIQ_DEPTH-1:0] stage_hit [DECODE_NUM-1:0];
  logic [AW-1:0]        stage_idx [DECODE_NUM-1:0];
  logic [DECODE_NUM-1:0] stage_found;

  // Entries left over after the last slot are intentionally dropped.
  logic [CIQ_DEPTH-1:0] leftover_unused;

  assign stage_vec[0]    = ciq_free;
  assign leftover_unused = stage_vec[DECODE_NUM];

  for (genvar k = 0; k < DECODE_NUM; k++) begin : g_slot
    ciq_ffs #(
      .WIDTH (CIQ_DEPTH)
    ) u_ffs (
      .vec    (stage_vec[k]),
      .idx    (stage_idx[k]),
      .found  (stage_found[k]),
      .onehot (stage_hit[k])
    );

    assign stage_vec[k+1] = stage_vec[k] & ~stage_hit[k];
  end

  logic [AW-1:0]         free_addr_d  [DECODE_NUM-1:0];
  logic [AW-1:0]         free_addr_q  [DECODE_NUM-1:0];
  logic [DECODE_NUM-1:0] free_valid_d;
  logic [DECODE_NUM-1:0] free_valid_q;

  // Unfound slots are forced to address 0 so the outputs never carry junk.
  always_comb begin
    free_valid_d = stage_found;
    for (int k = 0; k < DECODE_NUM; k++) begin
      free_addr_d[k] = stage_found[k] ? stage_idx[k] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      free_valid_q <= '0;
      for (int k = 0; k < DECODE_NUM; k++) begin
        free_addr_q[k] <= '0;
      end
    end else begin
      free_valid_q <= free_valid_d;
      for (int k = 0; k < DECODE_NUM; k++) begin
        free_addr_q[k] <= free_addr_d[k];
      end
    end
  end

  assign free_valid = free_valid_q;
  assign free_addr  = free_addr_q;

endmodule

// File: tb/tb_ciq_allocation.sv
module tb_ciq_allocation;

  import ciq_pkg::*;

  localparam int N  = 4;
  localparam int D  = 16;
  localparam int A  = 4;
  localparam int PW = N + N * A;  // packed result: {valid, addr3, addr2, addr1, addr0}

  logic          clk;
  logic          rst_n;
  logic [D-1:0]  ciq_free;
  logic [A-1:0]  free_addr [N-1:0];
  logic [N-1:0]  free_valid;

  int checks   = 0;
  int failures = 0;

  logic [PW-1:0] exp_q [$];

  ciq_allocation #(
    .DECODE_NUM (N),
    .CIQ_DEPTH  (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ciq_free   (ciq_free),
    .free_addr  (free_addr),
    .free_valid (free_valid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Collect free indices in ascending order, hand the first N to the slots.
  function automatic logic [PW-1:0] model(input logic [D-1:0] v);
    int        idx_q [$];
    ciq_addr_t a [N];
    logic [N-1:0] val;
    for (int i = 0; i < D; i++) if (v[i]) idx_q.push_back(i);
    val = '0;
    for (int k = 0; k < N; k++) begin
      if (k < idx_q.size()) begin
        val[k] = 1'b1;
        a[k]   = ciq_addr_t'(idx_q[k]);
      end else begin
        a[k] = '0;
      end
    end
    return {val, a[3], a[2], a[1], a[0]};
  endfunction

  function automatic logic [PW-1:0] actual();
    return {free_valid, free_addr[3], free_addr[2], free_addr[1], free_addr[0]};
  endfunction

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got valid=%b addr={%0d,%0d,%0d,%0d} expected valid=%b addr={%0d,%0d,%0d,%0d}",
               name, act[PW-1 -: N], act[15:12], act[11:8], act[7:4], act[3:0],
               exp[PW-1 -: N], exp[15:12], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  // ---------------- driver ----------------
  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic drive(input logic rst_v, input logic [D-1:0] v);
    @(negedge clk);
    rst_n    = rst_v;
    ciq_free = v;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_scored(input string name, input logic [D-1:0] v);
    exp_q.push_back(model(v));
    drive(1'b1, v);
    check(name, actual(), exp_q.pop_front());
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [D-1:0]  vec;
    logic [PW-1:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [D-1:0] v;
    int           m;

    tbl[0] = '{16'h0000, {4'b0000, 4'd0,  4'd0,  4'd0,  4'd0}};
    tbl[1] = '{16'h0001, {4'b0001, 4'd0,  4'd0,  4'd0,  4'd0}};
    tbl[2] = '{16'h000F, {4'b1111, 4'd3,  4'd2,  4'd1,  4'd0}};
    tbl[3] = '{16'h0070, {4'b0111, 4'd0,  4'd6,  4'd5,  4'd4}};
    tbl[4] = '{16'hF000, {4'b1111, 4'd15, 4'd14, 4'd13, 4'd12}};
    tbl[5] = '{16'hFFFF, {4'b1111, 4'd3,  4'd2,  4'd1,  4'd0}};
    tbl[6] = '{16'h8421, {4'b1111, 4'd15, 4'd10, 4'd5,  4'd0}};
    tbl[7] = '{16'h8000, {4'b0001, 4'd0,  4'd0,  4'd0,  4'd15}};

    rst_n    = 1'b0;
    ciq_free = 16'hFFFF;

    // Reset state, with free entries present on the input.
    drive(1'b0, 16'hFFFF);
    drive(1'b0, 16'h8421);
    check("reset_state", actual(), '0);

    // Directed vectors.
    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].vec);
      check($sformatf("table_%0d_%04h", i, tbl[i].vec), actual(), tbl[i].exp);
    end

    // Reset pulse mid-stream overrides an all-free input.
    drive(1'b1, 16'h00F0);
    drive(1'b0, 16'hFFFF);
    check("reset_midstream", actual(), '0);
    drive(1'b1, 16'hFFFF);
    check("after_reset", actual(), {4'b1111, 4'd3, 4'd2, 4'd1, 4'd0});

    // Random: exactly 1..4 bits set.
    for (int c = 0; c < 40; c++) begin
      m = $urandom_range(1, 4);
      v = '0;
      while ($countones(v) < m) v[$urandom_range(0, D - 1)] = 1'b1;
      drive_scored($sformatf("rand_sparse_%0d", c), v);
    end

    // Random: unconstrained vectors.
    for (int c = 0; c < 60; c++) begin
      v = D'($urandom);
      drive_scored($sformatf("rand_full_%0d", c), v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ciq_allocation.md
# ciq_allocation

Selects free entries in the collapsing issue queue (CIQ) for newly decoded instructions. Each cycle it scans the CIQ free-flag vector from index 0 upward and returns the addresses of the first `DECODE_NUM` free entries, each with a valid flag. It sits between the decode/rename stage, which consumes the addresses to write new entries, and the CIQ, which supplies the free flags. The results are registered, so they present one cycle after the free flags are sampled.

## Interface
- `DECODE_NUM`, default 4: number of allocation slots, equal to the decode width.
- `CIQ_DEPTH`, default 16: number of CIQ entries. Must be a power of 2 and ≥ `DECODE_NUM`.
- `AW` (derived, not overridable): `$clog2(CIQ_DEPTH)`, the address width (4 by default).

Ports:
- `clk`, input, 1: clock. One clock domain; all state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `ciq_free`, input, `CIQ_DEPTH`: bit i = 1 means CIQ entry i is free.
- `free_addr`, output, `DECODE_NUM` × `AW`, unpacked array `[DECODE_NUM-1:0]`: the address allocated to slot k.
- `free_valid`, output, `DECODE_NUM`: bit k = 1 means `free_addr[k]` holds a genuinely free entry.

## Operation
- Let F be the set of indices i with `ciq_free[i]` = 1, sorted ascending.
- Let n = min(|F|, `DECODE_NUM`).
- For slots k < n: `free_addr[k]` = F[k] and `free_valid[k]` = 1.
- For slots k ≥ n: `free_valid[k]` = 0 and `free_addr[k]` = 0. Never drive X.
- Consequences of this rule:
  - `free_valid` is always thermometer-coded from the LSB (0000, 0001, 0011, 0111 or 1111).
  - The valid addresses are strictly increasing with k.
  - No two valid slots ever carry the same address.
- Set bits beyond the `DECODE_NUM`-th free entry are ignored.
- The scan is fully combinational from `ciq_free`. Only the outputs are registered.

## Timing
- Latency is 1 cycle. `ciq_free` is sampled on rising edge N, and the corresponding result is visible on `free_addr`/`free_valid` after edge N and held until edge N+1.
- There is no handshake or back-pressure. A new result is produced every cycle.
- Reset: on any rising edge with `rst_n` = 0, all `free_valid` bits go to 0 and all `free_addr` values go to 0.
  - Reset overrides the sampled `ciq_free`.
  - Reset asserted mid-stream clears the outputs on that edge with no residual state.
  - The first edge with `rst_n` = 1 produces a normal result.
- All-zero `ciq_free` gives `free_valid` = 0 with no special casing. All-ones gives addresses 0..`DECODE_NUM`-1.
- Combinational depth is `DECODE_NUM` cascaded find-first-set stages over `CIQ_DEPTH` bits. It must close timing at the core clock for the default parameters.

## Structure
- Shared package (`ciq_pkg`) holds:
  - `CIQ_DEPTH`, `DECODE_NUM`, `CIQ_AW`;
  - the typedef `ciq_addr_t` (logic [`CIQ_AW`-1:0]).
- One sub-module, `ciq_ffs` (find-first-set), with parameter WIDTH.
  - Input: vector.
  - Outputs: index of the lowest set bit, found flag, and a one-hot of that bit.
- The top instantiates `DECODE_NUM` `ciq_ffs` in a cascade:
  - stage 0 sees `ciq_free`;
  - stage k sees stage k-1's input with stage k-1's one-hot cleared.
- Found flags feed `free_valid`; indices feed `free_addr`. Both pass through one output register bank with synchronous reset.

## Test plan
- Reset then `ciq_free` = 0x0000 → `free_valid` = 0000, all `free_addr` = 0.
- 0x0001 → `free_valid` = 0001, `free_addr[0]` = 0.
- 0x000F → `free_valid` = 1111, addresses 0,1,2,3.
- 0x0070 → `free_valid` = 0111, addresses 4,5,6.
- 0xF000 → addresses 12,13,14,15.
- 0xFFFF → addresses 0,1,2,3.
- 0x8421 → addresses 0,5,10,15.
- Random stream: 40 cycles of vectors with exactly 4, 3, 2 or 1 bits set, then unconstrained random vectors. Each output must match a software scan of the previous cycle's input.
- Assert `rst_n` = 0 for one edge while `ciq_free` = 0xFFFF → outputs all 0 that cycle. The next cycle gives addresses 0..3.
